// File: rtl/axis_tpg_pkg.sv
// ============================================================================
// axis_tpg_pkg
// ----------------------------------------------------------------------------
// Shared declarations for the AXI-Stream test-pattern burst scheduler.
//
// Contents:
//   state_e      - scheduler state (IDLE / RUN / GAP)
//   BURST_IDX_W  - width of the frame index output
//   BEAT_TOTAL_W - width of the accepted-beat total output
//   clog2_min1() - counter width helper that never returns less than 1 bit
// ============================================================================
package axis_tpg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam int BURST_IDX_W  = 16;
   localparam int BEAT_TOTAL_W = 32;

   // Width of a counter that must hold 0 .. value-1. Values of 0, 1 or 2 still
   // get one bit so that the counter declaration is never zero-width.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage : axis_tpg_pkg

// File: rtl/axis_testpattern_burst_ctrl.sv
// ============================================================================
// axis_testpattern_burst_ctrl
// ----------------------------------------------------------------------------
// Burst scheduler placed between the AXI-Stream test-pattern generator and the
// downstream consumer. It enables the generator, passes its stream through
// combinationally while a frame is open, cuts the stream into frames of
// BURST_LEN beats (tlast on the final beat), inserts GAP_CYCLES idle cycles
// between frames and stops after BURST_COUNT frames (0 = run until abort).
// An abort never truncates a frame: it takes effect at the next frame
// boundary, or immediately when the scheduler is already between frames.
//
// Parameters:
//   DATA_WIDTH  - tdata width, matches the generator's stream width
//   BURST_LEN   - beats per frame (>= 1)
//   BURST_COUNT - frames per run, 0 = unlimited
//   GAP_CYCLES  - idle cycles between frames, 0 = back-to-back frames
//
// Ports:
//   m_axis_aclk    in   clock, rising edge
//   m_axis_aresetn in   synchronous active-low reset
//   start          in   begin a run (accepted only in IDLE)
//   abort          in   stop at the next frame boundary
//   gen_enable     out  generator enable (high in RUN)
//   s_axis_*       in/out  stream from the generator (tdata, tvalid, tready)
//   m_axis_*       out/in  stream to the consumer (tdata, tvalid, tready, tlast)
//   busy           out  high while in RUN or GAP
//   done           out  one-cycle pulse in the first IDLE cycle after a run
//   burst_idx      out  index of the current frame, from 0
//   beat_total     out  beats accepted downstream since the last start
// ============================================================================
module axis_testpattern_burst_ctrl
   import axis_tpg_pkg::*;
#(
   parameter int DATA_WIDTH  = 24,
   parameter int BURST_LEN   = 16,
   parameter int BURST_COUNT = 4,
   parameter int GAP_CYCLES  = 8
) (
   input  logic                    m_axis_aclk,
   input  logic                    m_axis_aresetn,

   input  logic                    start,
   input  logic                    abort,
   output logic                    gen_enable,

   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,

   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,

   output logic                    busy,
   output logic                    done,
   output logic [BURST_IDX_W-1:0]  burst_idx,
   output logic [BEAT_TOTAL_W-1:0] beat_total
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   localparam int BEAT_CNT_W = clog2_min1(BURST_LEN);
   localparam int GAP_CNT_W  = clog2_min1(GAP_CYCLES);

   localparam logic [BEAT_CNT_W-1:0]  LAST_BEAT  = BEAT_CNT_W'(BURST_LEN - 1);
   localparam logic [GAP_CNT_W-1:0]   LAST_GAP   =
      GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic [BURST_IDX_W-1:0] LAST_BURST =
      BURST_IDX_W'((BURST_COUNT == 0) ? 0 : BURST_COUNT - 1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_e                    state_q,      state_d;
   logic [BEAT_CNT_W-1:0]     beat_cnt_q,   beat_cnt_d;
   logic [GAP_CNT_W-1:0]      gap_cnt_q,    gap_cnt_d;
   logic [BURST_IDX_W-1:0]    burst_idx_q,  burst_idx_d;
   logic [BEAT_TOTAL_W-1:0]   beat_total_q, beat_total_d;
   logic                      abort_pend_q, abort_pend_d;
   logic                      done_q,       done_d;
   logic                      busy_q,       busy_d;
   logic                      gen_en_q,     gen_en_d;

   // -------------------------------------------------------------------------
   // Stream path: zero-latency pass-through, closed outside RUN so the
   // generator holds any pending beat while the scheduler is idle or in a gap.
   // -------------------------------------------------------------------------
   logic in_run;
   logic beat;
   logic last_beat;
   logic run_complete;

   assign in_run        = (state_q == ST_RUN);
   assign m_axis_tdata  = in_run ? s_axis_tdata : '0;
   assign m_axis_tvalid = in_run & s_axis_tvalid;
   assign s_axis_tready = in_run & m_axis_tready;
   // tlast depends only on the beat counter, so it stays put while stalled.
   assign m_axis_tlast  = in_run & (beat_cnt_q == LAST_BEAT);

   assign beat      = m_axis_tvalid & m_axis_tready;
   assign last_beat = beat & (beat_cnt_q == LAST_BEAT);

   // A run ends at a frame boundary when the frame quota is reached or an
   // abort is pending; the abort sampled on the boundary beat itself counts.
   assign run_complete = ((BURST_COUNT != 0) && (burst_idx_q == LAST_BURST)) ||
                         abort_pend_q || abort;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d signal is defaulted to its register first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      burst_idx_d  = burst_idx_q;
      beat_total_d = beat_total_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_RUN;
               beat_cnt_d   = '0;
               gap_cnt_d    = '0;
               burst_idx_d  = '0;
               beat_total_d = '0;
               // start wins over a simultaneous abort, which is remembered.
               abort_pend_d = abort;
            end
         end

         ST_RUN: begin
            if (abort) begin
               abort_pend_d = 1'b1;
            end
            if (beat) begin
               beat_cnt_d   = beat_cnt_q + 1'b1;
               beat_total_d = beat_total_q + 1'b1;
            end
            if (last_beat) begin
               beat_cnt_d = '0;
               if (run_complete) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (GAP_CYCLES == 0) begin
                  burst_idx_d = burst_idx_q + 1'b1;
               end else begin
                  state_d     = ST_GAP;
                  burst_idx_d = burst_idx_q + 1'b1;
                  gap_cnt_d   = '0;
               end
            end
         end

         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (abort || abort_pend_q) begin
               // Nothing is in flight between frames, so stop right away.
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (gap_cnt_q == LAST_GAP) begin
               state_d   = ST_RUN;
               gap_cnt_d = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // exactly with the state register rather than lagging it by a cycle.
      busy_d   = (state_d != ST_IDLE);
      gen_en_d = (state_d == ST_RUN);
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the values computed before this edge, independent of
   // statement order.
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         state_q      <= ST_IDLE;
         beat_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         burst_idx_q  <= '0;
         beat_total_q <= '0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         gen_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         burst_idx_q  <= burst_idx_d;
         beat_total_q <= beat_total_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         gen_en_q     <= gen_en_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign gen_enable = gen_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign burst_idx  = burst_idx_q;
   assign beat_total = beat_total_q;

endmodule : axis_testpattern_burst_ctrl

// File: tb/tb_axis_testpattern_burst_ctrl.sv
// ============================================================================
// tb_axis_testpattern_burst_ctrl
// ----------------------------------------------------------------------------
// Directed bench for the burst scheduler. Two instances share one clock:
//   index 0 : BURST_LEN=4, BURST_COUNT=2, GAP_CYCLES=3
//   index 1 : BURST_LEN=3, BURST_COUNT=0, GAP_CYCLES=0 (continuous)
// Each instance is fed by a small generator model that emits 1,2,3,... and
// obeys the AXIS hold rule. A negedge monitor records the accepted beats of
// the selected instance; stimulus is driven 1 ns after the rising edge.
// ============================================================================
module tb_axis_testpattern_burst_ctrl;

   localparam int DW = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic          start_s    [2];
   logic          abort_s    [2];
   logic          m_ready    [2];
   logic          gen_en     [2];
   logic [DW-1:0] s_tdata    [2];
   logic          s_tvalid   [2];
   logic          s_tready   [2];
   logic [DW-1:0] m_tdata    [2];
   logic          m_tvalid   [2];
   logic          m_tlast    [2];
   logic          busy       [2];
   logic          done       [2];
   logic [15:0]   bidx       [2];
   logic [31:0]   btot       [2];

   axis_testpattern_burst_ctrl #(
      .DATA_WIDTH (DW), .BURST_LEN (4), .BURST_COUNT (2), .GAP_CYCLES (3)
   ) u_dut (
      .m_axis_aclk    (clk),         .m_axis_aresetn (rstn),
      .start          (start_s[0]),  .abort          (abort_s[0]),
      .gen_enable     (gen_en[0]),
      .s_axis_tdata   (s_tdata[0]),  .s_axis_tvalid  (s_tvalid[0]),
      .s_axis_tready  (s_tready[0]),
      .m_axis_tdata   (m_tdata[0]),  .m_axis_tvalid  (m_tvalid[0]),
      .m_axis_tready  (m_ready[0]),  .m_axis_tlast   (m_tlast[0]),
      .busy           (busy[0]),     .done           (done[0]),
      .burst_idx      (bidx[0]),     .beat_total     (btot[0])
   );

   axis_testpattern_burst_ctrl #(
      .DATA_WIDTH (DW), .BURST_LEN (3), .BURST_COUNT (0), .GAP_CYCLES (0)
   ) u_dut_cont (
      .m_axis_aclk    (clk),         .m_axis_aresetn (rstn),
      .start          (start_s[1]),  .abort          (abort_s[1]),
      .gen_enable     (gen_en[1]),
      .s_axis_tdata   (s_tdata[1]),  .s_axis_tvalid  (s_tvalid[1]),
      .s_axis_tready  (s_tready[1]),
      .m_axis_tdata   (m_tdata[1]),  .m_axis_tvalid  (m_tvalid[1]),
      .m_axis_tready  (m_ready[1]),  .m_axis_tlast   (m_tlast[1]),
      .busy           (busy[1]),     .done           (done[1]),
      .burst_idx      (bidx[1]),     .beat_total     (btot[1])
   );

   // -------------------------------------------------------------------------
   // Generator model: counting pattern starting at 1, valid whenever enabled,
   // a pending beat is held until it is accepted.
   // -------------------------------------------------------------------------
   logic gen_clr;

   always_ff @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rstn || gen_clr) begin
            s_tdata[g]  <= DW'(1);
            s_tvalid[g] <= 1'b0;
         end else begin
            if (s_tvalid[g] && s_tready[g]) s_tdata[g] <= s_tdata[g] + 1'b1;
            s_tvalid[g] <= (s_tvalid[g] && !s_tready[g]) || gen_en[g];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Monitor (negedge) for the selected instance
   // -------------------------------------------------------------------------
   int          sel;
   logic        mon_clr;
   int          nbeats;
   logic [DW-1:0] beat_data [0:63];
   logic        beat_last [0:63];
   logic [15:0] beat_bidx [0:63];
   int          stall_cnt;
   int          done_cnt;
   int          done_busy_err;
   int          hold_err;
   logic        hold_pend;
   logic        in_gap;

   always @(negedge clk) begin
      if (mon_clr) begin
         nbeats        <= 0;
         stall_cnt     <= 0;
         done_cnt      <= 0;
         done_busy_err <= 0;
         hold_err      <= 0;
         hold_pend     <= 1'b0;
         in_gap        <= 1'b0;
      end else begin
         if (m_tvalid[sel] && m_ready[sel] && nbeats < 63) begin
            nbeats                <= nbeats + 1;
            beat_data[nbeats + 1] <= m_tdata[sel];
            beat_last[nbeats + 1] <= m_tlast[sel];
            beat_bidx[nbeats + 1] <= bidx[sel];
         end
         if (busy[sel] && !s_tready[sel]) stall_cnt <= stall_cnt + 1;
         if (done[sel]) begin
            done_cnt <= done_cnt + 1;
            if (busy[sel]) done_busy_err <= done_busy_err + 1;
         end
         if (hold_pend && !(m_tvalid[sel] && m_tlast[sel])) hold_err <= hold_err + 1;
         hold_pend <= m_tvalid[sel] && m_tlast[sel] && !m_ready[sel];
         in_gap    <= busy[sel] && !gen_en[sel];
      end
   end

   // -------------------------------------------------------------------------
   // Checking
   // -------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Recorded beats must be 1..n_exp, tlast every blen beats, frame index
   // advancing once per frame.
   task automatic check_stream(input string tag, input int n_exp, input int blen);
      int err_data = 0;
      int err_last = 0;
      int err_bidx = 0;
      check({tag, "_nbeats"}, nbeats, n_exp);
      for (int i = 1; i <= nbeats && i <= 63; i++) begin
         if (beat_data[i] !== DW'(i))                err_data++;
         if (beat_last[i] !== ((i % blen) == 0))     err_last++;
         if (beat_bidx[i] !== 16'((i - 1) / blen))   err_bidx++;
      end
      check({tag, "_data_err"}, err_data, 0);
      check({tag, "_tlast_err"}, err_last, 0);
      check({tag, "_bidx_err"}, err_bidx, 0);
   endtask

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   int         cyc = 0;
   int         ready_mode = 0;
   logic [3:0] pat = 4'b1001;   // consumer ready sequence 1,0,0,1

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int g = 0; g < 2; g++)
         m_ready[g] = (ready_mode == 0) ? 1'b1 : pat[cyc % 4];
   endtask

   task automatic prep();
      gen_clr = 1'b1;
      mon_clr = 1'b1;
      tick();
      gen_clr = 1'b0;
      mon_clr = 1'b0;
   endtask

   task automatic do_start();
      start_s[sel] = 1'b1;
      tick();
      start_s[sel] = 1'b0;
   endtask

   task automatic do_abort();
      abort_s[sel] = 1'b1;
      tick();
      abort_s[sel] = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && done_cnt == 0; k++) tick();
   endtask

   // -------------------------------------------------------------------------
   // Test sequence
   // -------------------------------------------------------------------------
   initial begin
      rstn    = 1'b0;
      gen_clr = 1'b0;
      mon_clr = 1'b1;
      sel     = 0;
      for (int g = 0; g < 2; g++) begin
         start_s[g] = 1'b0;
         abort_s[g] = 1'b0;
         m_ready[g] = 1'b1;
      end
      tick();
      tick();

      // Reset state
      check("rst_gen_en",  gen_en[0],   0);
      check("rst_busy",    busy[0],     0);
      check("rst_done",    done[0],     0);
      check("rst_tvalid",  m_tvalid[0], 0);
      check("rst_tlast",   m_tlast[0],  0);
      check("rst_tready",  s_tready[0], 0);
      check("rst_bidx",    bidx[0],     0);
      check("rst_btot",    btot[0],     0);
      check("rst_c_busy",  busy[1],     0);
      rstn = 1'b1;
      tick();

      // 1: two frames of 4 with a 3-cycle gap, consumer always ready
      sel = 0;
      prep();
      do_start();
      check("t1_gen_en_latency", gen_en[0], 1);
      check("t1_busy_latency",   busy[0],   1);
      wait_done(100);
      repeat (6) tick();
      check_stream("t1", 8, 4);
      check("t1_gap_cycles",  stall_cnt,     3);
      check("t1_done_cnt",    done_cnt,      1);
      check("t1_done_busy",   done_busy_err, 0);
      check("t1_beat_total",  btot[0],       8);
      check("t1_bidx_end",    bidx[0],       1);
      check("t1_idle_tready", s_tready[0],   0);

      // 2: consumer ready toggling 1-0-0-1
      ready_mode = 1;
      prep();
      do_start();
      wait_done(200);
      repeat (6) tick();
      check_stream("t2", 8, 4);
      check("t2_tlast_hold", hold_err, 0);
      check("t2_done_cnt",   done_cnt, 1);
      check("t2_beat_total", btot[0],  8);
      ready_mode = 0;
      tick();

      // 3: abort during beat 2 of frame 0
      prep();
      do_start();
      for (int k = 0; k < 50 && nbeats < 1; k++) tick();
      do_abort();
      wait_done(100);
      repeat (10) tick();
      check_stream("t3", 4, 4);
      check("t3_done_cnt",   done_cnt, 1);
      check("t3_bidx_end",   bidx[0],  0);
      check("t3_beat_total", btot[0],  4);

      // 4: abort while in the gap
      prep();
      do_start();
      for (int k = 0; k < 50 && !in_gap; k++) tick();
      check("t4_reached_gap", in_gap, 1);
      do_abort();
      check("t4_idle_next",  busy[0],     0);
      check("t4_done_next",  done[0],     1);
      check("t4_tvalid",     m_tvalid[0], 0);
      repeat (10) tick();
      check_stream("t4", 4, 4);
      check("t4_done_cnt",   done_cnt, 1);
      check("t4_beat_total", btot[0],  4);
      check("t4_bidx_end",   bidx[0],  1);

      // 5: continuous frames, start while busy ignored, abort ends run
      sel = 1;
      prep();
      do_start();
      for (int k = 0; k < 200 && nbeats < 5; k++) tick();
      do_start();
      for (int k = 0; k < 200 && nbeats < 30; k++) tick();
      do_abort();
      wait_done(100);
      repeat (5) tick();
      check_stream("t5", 33, 3);
      check("t5_done_cnt",   done_cnt,      1);
      check("t5_done_busy",  done_busy_err, 0);
      check("t5_beat_total", btot[1],       33);
      check("t5_bidx_end",   bidx[1],       10);

      // 6: reset mid-frame, then restart
      sel = 0;
      prep();
      do_start();
      for (int k = 0; k < 50 && nbeats < 2; k++) tick();
      rstn = 1'b0;
      tick();
      check("t6_gen_en", gen_en[0],   0);
      check("t6_busy",   busy[0],     0);
      check("t6_done",   done[0],     0);
      check("t6_tvalid", m_tvalid[0], 0);
      check("t6_tlast",  m_tlast[0],  0);
      check("t6_tready", s_tready[0], 0);
      check("t6_bidx",   bidx[0],     0);
      check("t6_btot",   btot[0],     0);
      rstn = 1'b1;
      repeat (5) tick();
      check("t6_no_done", done_cnt, 0);
      prep();
      do_start();
      check("t6_restart_bidx", bidx[0], 0);
      check("t6_restart_btot", btot[0], 0);
      check("t6_restart_busy", busy[0], 1);
      wait_done(100);
      repeat (6) tick();
      check_stream("t6", 8, 4);
      check("t6_done_cnt",   done_cnt, 1);
      check("t6_beat_total", btot[0],  8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_axis_testpattern_burst_ctrl
